// File: rtl/mem_bus_pkg.sv
// Shared types for the memory strobe bus between the control unit and bus_mem_responder.
package mem_bus_pkg;
   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_DONE,
      ST_HOLD
   } mem_state_e;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } mem_dir_e;
endpackage

// File: rtl/bus_mem_responder_if.sv
// Memory strobe/address/handshake bundle; the bidirectional data bus stays a plain net.
interface bus_mem_responder_if
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) ();
   logic              mem_ce;
   logic              mem_r;
   logic              mem_w;
   logic              mem_oe;
   logic [ADDR_W-1:0] addr_bus;
   logic              mem_rdy;
   logic              mem_err;

   modport master (
      output mem_ce, mem_r, mem_w, mem_oe, addr_bus,
      input  mem_rdy, mem_err
   );

   modport slave (
      input  mem_ce, mem_r, mem_w, mem_oe, addr_bus,
      output mem_rdy, mem_err
   );
endinterface

// File: rtl/mem_ram_array.sv
// DEPTH x DATA_W storage: synchronous write, registered read; array 'mem' is left uninitialised.
module mem_ram_array #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic              rclr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   // rclr wins so an out-of-range read returns zero rather than stale data
   always_comb begin
      rdata_d = rdata_q;
      if (rclr) begin
         rdata_d = '0;
      end else if (re) begin
         rdata_d = mem[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder: wait-state insertion, RAM access, rdy/err pulses, gated data_bus drive.
// Define MEM_RO_REGION_EN to make addresses below RO_LIMIT read-only.
//
//   state     | meaning
//   ST_IDLE   | no request; waiting for mem_ce with one strobe
//   ST_WAIT   | request captured, counting down wait states
//   ST_ACCESS | RAM write commit or read load
//   ST_DONE   | mem_rdy pulse (mem_err alongside if rejected)
//   ST_HOLD   | response given; waiting for mem_ce to drop
module bus_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned RO_LIMIT    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   bus_mem_responder_if.slave  bus_if,
   inout  wire  [DATA_W-1:0]   data_bus
);
   localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   mem_dir_e          dir_q, dir_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;

   logic              in_range, ro_hit, reject;
   logic              ram_we, ram_re, ram_rclr;
   logic [DATA_W-1:0] ram_rdata;
   logic              drive;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);

`ifdef MEM_RO_REGION_EN
   localparam logic [ADDR_W:0] RO_L = (ADDR_W + 1)'(RO_LIMIT);
   assign ro_hit = (dir_q == DIR_WRITE) && ({1'b0, addr_q} < RO_L);
`else
   assign ro_hit = 1'b0;
`endif

   assign reject = !in_range || ro_hit;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      dir_d    = dir_q;
      rvalid_d = rvalid_q;
      err_d    = err_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_rclr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rvalid_d = 1'b0;
            if (bus_if.mem_ce && bus_if.mem_r && bus_if.mem_w) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (bus_if.mem_ce && (bus_if.mem_r ^ bus_if.mem_w)) begin
               addr_d  = bus_if.addr_bus;
               wdata_d = data_bus;
               dir_d   = bus_if.mem_r ? DIR_READ : DIR_WRITE;
               err_d   = 1'b0;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACCESS;
               end else begin
                  cnt_d   = CNT_W'(WAIT_STATES - 1);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!bus_if.mem_ce) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ACCESS: begin
            // the commit happens on this edge even if mem_ce has just dropped
            err_d = reject;
            if (dir_q == DIR_WRITE) begin
               ram_we = !reject;
            end else begin
               rvalid_d = 1'b1;
               ram_re   = in_range;
               ram_rclr = !in_range;
            end
            if (bus_if.mem_ce) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!bus_if.mem_ce) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         dir_q    <= DIR_READ;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         dir_q    <= dir_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   mem_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .re    (ram_re),
      .rclr  (ram_rclr),
      .idx   (addr_q[IDX_W-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign bus_if.mem_rdy = (state_q == ST_DONE);
   assign bus_if.mem_err = (state_q == ST_DONE) && err_q;

   // drive falls away combinationally with mem_ce/mem_oe, and asynchronously on reset via rvalid_q
   assign drive    = rvalid_q && bus_if.mem_ce && bus_if.mem_oe && (dir_q == DIR_READ);
   assign data_bus = drive ? ram_rdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (WAIT_STATES 1 and 3), a transaction-level model, directed vectors.
module tb_bus_mem_responder;
   localparam int NI = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0] ce_s, r_s, w_s, oe_s, drv_en;
   logic [15:0]   addr_s [NI];
   logic [7:0]    drv_d  [NI];
   logic [NI-1:0] rdy_s, err_s;
   logic [7:0]    bus_s  [NI];
   wire  [7:0]    data_bus0, data_bus1;

   int checks   = 0;
   int failures = 0;

   bus_mem_responder_if if0 ();
   bus_mem_responder_if if1 ();

   assign if0.mem_ce   = ce_s[0];
   assign if0.mem_r    = r_s[0];
   assign if0.mem_w    = w_s[0];
   assign if0.mem_oe   = oe_s[0];
   assign if0.addr_bus = addr_s[0];
   assign if1.mem_ce   = ce_s[1];
   assign if1.mem_r    = r_s[1];
   assign if1.mem_w    = w_s[1];
   assign if1.mem_oe   = oe_s[1];
   assign if1.addr_bus = addr_s[1];
   assign rdy_s[0] = if0.mem_rdy;
   assign err_s[0] = if0.mem_err;
   assign rdy_s[1] = if1.mem_rdy;
   assign err_s[1] = if1.mem_err;

   assign data_bus0 = drv_en[0] ? drv_d[0] : 8'hzz;
   assign data_bus1 = drv_en[1] ? drv_d[1] : 8'hzz;
   pulldown (data_bus0);
   pulldown (data_bus1);
   assign bus_s[0] = data_bus0;
   assign bus_s[1] = data_bus1;

   bus_mem_responder #(.WAIT_STATES(1)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_if   (if0),
      .data_bus (data_bus0)
   );

   bus_mem_responder #(.WAIT_STATES(3)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_if   (if1),
      .data_bus (data_bus1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int i);
      logic [7:0] v;
      v = 8'(i);
      return v ^ 8'h3c;
   endfunction

   // Transaction model: one request per mem_ce assertion, committed at capture+1+ws.
   logic [7:0]  m_mem   [NI][256];
   bit          m_busy  [NI];
   bit          m_done  [NI];
   bit          m_hold  [NI];
   bit          m_err   [NI];
   bit          m_rvalid[NI];
   bit          m_read  [NI];
   int          m_due   [NI];
   logic [15:0] m_addr  [NI];
   logic [7:0]  m_wd    [NI];
   logic [7:0]  m_rdata [NI];
   int          cyc = 0;

   function automatic void model_edge(input int k);
      int  ws;
      bit  in_rng, ro;
      ws = (k == 0) ? 1 : 3;
      if (m_hold[k]) begin
         if (!ce_s[k]) begin
            m_hold[k]   = 1'b0;
            m_rvalid[k] = 1'b0;
         end
      end else if (m_done[k]) begin
         m_done[k] = 1'b0;
         m_hold[k] = 1'b1;
      end else if (m_busy[k]) begin
         if (cyc == m_due[k]) begin
            in_rng = (m_addr[k] < 16'd256);
`ifdef MEM_RO_REGION_EN
            ro = !m_read[k] && (m_addr[k] < 16'd16);
`else
            ro = 1'b0;
`endif
            if (!m_read[k] && in_rng && !ro) m_mem[k][m_addr[k][7:0]] = m_wd[k];
            if (m_read[k]) begin
               m_rdata[k]  = in_rng ? m_mem[k][m_addr[k][7:0]] : 8'h00;
               m_rvalid[k] = 1'b1;
            end
            m_busy[k] = 1'b0;
            if (ce_s[k]) begin
               m_done[k] = 1'b1;
               m_err[k]  = !in_rng || ro;
            end else begin
               m_rvalid[k] = 1'b0;
            end
         end else if (!ce_s[k]) begin
            m_busy[k] = 1'b0;
         end
      end else if (ce_s[k] && r_s[k] && w_s[k]) begin
         m_done[k] = 1'b1;
         m_err[k]  = 1'b1;
      end else if (ce_s[k] && (r_s[k] ^ w_s[k])) begin
         m_busy[k] = 1'b1;
         m_due[k]  = cyc + 1 + ws;
         m_addr[k] = addr_s[k];
         m_read[k] = r_s[k];
         m_wd[k]   = drv_d[k];
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b0; m_hold[k] = 1'b0;
            m_err[k] = 1'b0;  m_rvalid[k] = 1'b0;
         end
      end else begin
         cyc++;
         for (int k = 0; k < NI; k++) model_edge(k);
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         logic [7:0] exp_bus;
         exp_bus = (m_rvalid[k] && m_read[k] && ce_s[k] && oe_s[k]) ? m_rdata[k] : 8'h00;
         chk($sformatf("dut%0d.mem_rdy", k), 32'(rdy_s[k]), 32'(m_done[k]));
         chk($sformatf("dut%0d.mem_err", k), 32'(err_s[k]), 32'(m_done[k] && m_err[k]));
         if (!drv_en[k]) chk($sformatf("dut%0d.data_bus", k), 32'(bus_s[k]), 32'(exp_bus));
      end
   end

   // Issues a request and waits (bounded) for mem_rdy; strobes stay asserted on return.
   task automatic access(input int k, input logic r, input logic w, input logic [15:0] a,
                         input logic [7:0] d, output int lat, output logic e, output logic [7:0] rd);
      @(posedge clk); #2;
      ce_s[k] = 1'b1; r_s[k] = r; w_s[k] = w; oe_s[k] = r;
      addr_s[k] = a; drv_d[k] = d; drv_en[k] = w;
      lat = -1; e = 1'b0; rd = 8'h00;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         @(negedge clk);
         if (rdy_s[k]) begin
            lat = i - 1; e = err_s[k]; rd = bus_s[k];
         end
      end
   endtask

   task automatic release_bus(input int k);
      @(posedge clk); #2;
      ce_s[k] = 1'b0; r_s[k] = 1'b0; w_s[k] = 1'b0; oe_s[k] = 1'b0; drv_en[k] = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic count_rdy(input int k, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (rdy_s[k]) cnt++;
      end
   endtask

   initial begin
      int lat, cnt;
      logic e;
      logic [7:0] rd;
      ce_s = '0; r_s = '0; w_s = '0; oe_s = '0; drv_en = '0;
      for (int k = 0; k < NI; k++) begin
         addr_s[k] = 16'h0; drv_d[k] = 8'h00;
      end
      #1 rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         u_dut0.u_ram.mem[i] = pat(i);
         u_dut1.u_ram.mem[i] = pat(i);
         m_mem[0][i] = pat(i);
         m_mem[1][i] = pat(i);
      end
      u_dut0.u_ram.mem[3] = 8'hff;
      m_mem[0][3] = 8'hff;
      repeat (2) @(negedge clk);
      chk("reset.rdy", 32'(rdy_s), 32'h0);
      chk("reset.err", 32'(err_s), 32'h0);
      chk("reset.bus0", 32'(bus_s[0]), 32'h00);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // read preloaded ff, then drop oe
      access(0, 1'b1, 1'b0, 16'd3, 8'h00, lat, e, rd);
      chk("rd3.latency", 32'(lat), 32'd3);
      chk("rd3.err", 32'(e), 32'h0);
      chk("rd3.data", 32'(rd), 32'hff);
      @(posedge clk); #2 oe_s[0] = 1'b0;
      @(negedge clk);
      chk("rd3.bus_oe_off", 32'(bus_s[0]), 32'h00);
      release_bus(0);

      // write then read back
      access(0, 1'b0, 1'b1, 16'd20, 8'h5a, lat, e, rd);
      chk("wr20.latency", 32'(lat), 32'd3);
      chk("wr20.err", 32'(e), 32'h0);
      release_bus(0);
      chk("wr20.mem", 32'(u_dut0.u_ram.mem[20]), 32'h5a);
      access(0, 1'b1, 1'b0, 16'd20, 8'h00, lat, e, rd);
      chk("rd20.data", 32'(rd), 32'h5a);
      chk("rd20.err", 32'(e), 32'h0);
      release_bus(0);

      // out of range
      access(0, 1'b1, 1'b0, 16'h0100, 8'h00, lat, e, rd);
      chk("rd100.err", 32'(e), 32'h1);
      chk("rd100.data", 32'(rd), 32'h00);
      release_bus(0);
      access(0, 1'b0, 1'b1, 16'h0100, 8'h77, lat, e, rd);
      chk("wr100.err", 32'(e), 32'h1);
      release_bus(0);
      chk("wr100.mem0", 32'(u_dut0.u_ram.mem[0]), 32'h3c);

      // abort during wait states on the 3-wait-state instance
      @(posedge clk); #2;
      ce_s[1] = 1'b1; w_s[1] = 1'b1; addr_s[1] = 16'd5; drv_d[1] = 8'h11; drv_en[1] = 1'b1;
      @(posedge clk); #2;
      ce_s[1] = 1'b0; w_s[1] = 1'b0; drv_en[1] = 1'b0;
      count_rdy(1, 8, cnt);
      chk("abort.rdy_count", 32'(cnt), 32'd0);
      chk("abort.mem5", 32'(u_dut1.u_ram.mem[5]), 32'h39);
      access(1, 1'b1, 1'b0, 16'd5, 8'h00, lat, e, rd);
      chk("ws3.rd5.latency", 32'(lat), 32'd5);
      chk("ws3.rd5.data", 32'(rd), 32'h39);
      release_bus(1);
      access(1, 1'b0, 1'b1, 16'd40, 8'ha5, lat, e, rd);
      chk("ws3.wr40.err", 32'(e), 32'h0);
      release_bus(1);
      chk("ws3.wr40.mem", 32'(u_dut1.u_ram.mem[40]), 32'ha5);

      // both strobes: error, then no second response while ce stays high
      access(0, 1'b1, 1'b1, 16'd20, 8'h99, lat, e, rd);
      chk("rw.latency", 32'(lat), 32'd1);
      chk("rw.err", 32'(e), 32'h1);
      count_rdy(0, 4, cnt);
      chk("rw.hold_rdy_count", 32'(cnt), 32'd0);
      release_bus(0);
      chk("rw.mem20", 32'(u_dut0.u_ram.mem[20]), 32'h5a);

      // read-only region
      access(0, 1'b0, 1'b1, 16'd2, 8'haa, lat, e, rd);
      release_bus(0);
`ifdef MEM_RO_REGION_EN
      chk("ro.err", 32'(e), 32'h1);
      chk("ro.mem2", 32'(u_dut0.u_ram.mem[2]), 32'h3e);
`else
      chk("ro.err", 32'(e), 32'h0);
      chk("ro.mem2", 32'(u_dut0.u_ram.mem[2]), 32'haa);
`endif

      // ce dropped on the edge leaving ACCESS: write lands, no rdy
      @(posedge clk); #2;
      ce_s[0] = 1'b1; w_s[0] = 1'b1; addr_s[0] = 16'd30; drv_d[0] = 8'hc3; drv_en[0] = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      ce_s[0] = 1'b0; w_s[0] = 1'b0; drv_en[0] = 1'b0;
      count_rdy(0, 6, cnt);
      chk("late_drop.rdy_count", 32'(cnt), 32'd0);
      chk("late_drop.mem30", 32'(u_dut0.u_ram.mem[30]), 32'hc3);

      // reset while driving read data releases the bus at once
      access(0, 1'b1, 1'b0, 16'd20, 8'h00, lat, e, rd);
      chk("rst_rd.data", 32'(rd), 32'h5a);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("rst_rd.bus_released", 32'(bus_s[0]), 32'h00);
      chk("rst_rd.rdy", 32'(rdy_s[0]), 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      release_bus(0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
